wdma_ctrl: RTL and testbench
============================

# wdma_ctrl

Sequencing controller for the write-DMA path: it accepts a base address and a word count, then drives a 32-bit stream into DRAM as a series of AXI4 INCR write bursts. It issues the AW, W and B channels one burst at a time and reports completion through the ap_* block-level handshake. It sits between the stream FIFO output and the DRAM AXI master port.

## Interface
- ADDR_W, 32, byte-address width
- LEN_W, 24, word-count width
- MAX_BURST, 16, beats per burst (1..256)
- ap_clk  in  1  clock; all logic on its rising edge
- ap_rst  in  1  asynchronous, active-high reset
- ap_start  in  1  start request, sampled in IDLE only
- ap_done / ap_ready  out  1  one-cycle completion pulse (both identical)
- ap_idle  out  1  high in IDLE
- cfg_base_addr  in  ADDR_W  byte address, 4-byte aligned, latched on start
- cfg_len_words  in  LEN_W  transfer length in 32-bit words, latched on start
- s_axis_tdata / tvalid / tready  in/in/out  32/1/1  input word stream
- m_axi_awaddr / awlen / awvalid / awready  out/out/out/in  ADDR_W/8/1/1  AW channel
- m_axi_wdata / wlast / wvalid / wready  out/out/out/in  32/1/1/1  W channel (wstrb fixed 4'hF, internal)
- m_axi_bresp / bvalid / bready  in/in/out  2/1/1  B channel
- err  out  1  sticky write-error flag

## Operation
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
- IDLE: if ap_start=1, latch addr=cfg_base_addr and rem=cfg_len_words. If rem=0, go to DONE; otherwise go to ADDR.
- ADDR: beats=min(rem,MAX_BURST), registered on entry. Drive awaddr=addr, awlen=beats-1, awvalid=1. On awready, go to DATA with beat_cnt=0.
- DATA: W is a combinational pass-through.
  - wvalid=tvalid, tready=wready, wdata=tdata.
  - wlast=(beat_cnt==beats-1).
  - Each handshake increments beat_cnt. The handshake on the last beat moves to RESP.
- RESP: bready=1. On bvalid: addr+=beats*4 (mod 2^ADDR_W), rem-=beats. If rem=0 go to DONE, else go to ADDR.
- DONE: assert ap_done=ap_ready=1 for exactly one cycle, then return to IDLE.
- At most one burst is outstanding. The AW handshake always precedes the first W beat of its burst.
- ap_start outside IDLE is ignored. cfg_* changes after latching have no effect.
- Bursts are not split at 4 KB boundaries. Software must keep transfers inside a 4 KB page when MAX_BURST×4 could cross one.

## Timing
- Reset values: FSM=IDLE, ap_idle=1, ap_done=ap_ready=0, awvalid=0, wvalid=0, wlast=0, tready=0, bready=0, err=0, awaddr=0, awlen=0.
- Registered: awvalid, awaddr, awlen, bready, ap_*. Combinational in DATA: wvalid, tready, wlast.
- awvalid stays high, with stable awaddr/awlen, until awready. It is never withdrawn.
- Minimum latency for one burst of N beats with zero stalls is N+4 cycles from start to the ap_done pulse: 1 ADDR, N DATA, 1 RESP, 1 DONE, plus the IDLE sample cycle.
- The cycle after ap_done, ap_idle=1 and a new ap_start is accepted.
- Zero-length transfer: ap_done pulses 2 cycles after ap_start, with no AXI activity.
- Stalls: tvalid=0 or wready=0 freezes beat_cnt with no data loss.
- Reset mid-transfer returns all outputs to their reset values immediately (asynchronously). The partial burst is abandoned; the interconnect is reset with the block.

## Configuration
- WDMA_CTRL_BRESP_CHECK_EN defined:
  - A bresp other than OKAY (2'b00) in RESP sets err.
  - The FSM then skips the remaining bursts and goes to DONE.
  - err clears on the next accepted ap_start.
- Not defined: bresp is ignored, err is tied 0, and every burst always completes.

## Structure
- Shared package wdma_pkg holds:
  - the FSM state enum (wdma_state_t);
  - AXI_RESP_OKAY=2'b00;
  - BYTES_PER_WORD=4;
  - the default MAX_BURST.
- Single module, no sub-modules. The burst-size computation (min, awlen) is inline.

## Test plan
- Base 0x1000, len 16, MAX_BURST 16, no stalls: one AW (0x1000, awlen 15), 16 W beats with wlast on the 16th, ap_done 20 cycles after start.
- Len 40: AWs 0x1000/15, 0x1040/15, 0x1080/7. wlast on beats 16, 32, 40. Data order matches the stream.
- Len 0: no awvalid, ap_done exactly 2 cycles after ap_start, ap_idle=1 throughout except that window.
- Random tvalid/wready/awready/bvalid backpressure, len 37: all 37 words are written exactly once, in order, and awvalid/awaddr stay stable while waiting.
- With WDMA_CTRL_BRESP_CHECK_EN, len 48, SLVERR on the first bresp: err=1, only one AW is issued, and ap_done pulses. On the next start, err=0.
- Assert ap_rst during the DATA state of the second burst: all outputs return to reset values in the same cycle. A fresh transfer of len 4 then completes normally.

Source files
------------

// File: rtl/wdma_ctrl_pkg.sv
// wdma_ctrl_pkg: shared types and constants for the write-DMA controller (package wdma_pkg).
package wdma_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} wdma_state_t;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int BYTES_PER_WORD = 4;
    localparam int MAX_BURST_DEF = 16;
endpackage

// File: rtl/wdma_ctrl_if.sv
// wdma_ctrl_if: input word stream plus AXI4 AW/W/B write channels of the write-DMA path.
interface wdma_ctrl_if #(parameter int ADDR_W = 32);
    logic [31:0]       s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [31:0]       m_axi_wdata;
    logic              m_axi_wlast;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    modport master (
        input  s_axis_tdata, s_axis_tvalid, m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        output s_axis_tready, m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
               m_axi_wdata, m_axi_wlast, m_axi_wvalid, m_axi_bready
    );
    modport slave (
        output s_axis_tdata, s_axis_tvalid, m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        input  s_axis_tready, m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
               m_axi_wdata, m_axi_wlast, m_axi_wvalid, m_axi_bready
    );
endinterface

// File: rtl/wdma_ctrl.sv
// wdma_ctrl: streams words into DRAM as single-outstanding AXI4 INCR bursts with ap_* handshake.
// Optional WDMA_CTRL_BRESP_CHECK_EN: non-OKAY bresp sets sticky err and aborts remaining bursts.
module wdma_ctrl
    import wdma_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 24,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_ready,
    output logic              ap_idle,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [LEN_W-1:0]  cfg_len_words,
    wdma_ctrl_if.master       bus,
    output logic              err
);
    localparam int BW = $clog2(MAX_BURST + 1);

    wdma_state_t       state;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [LEN_W-1:0]  rem, rem_nxt;
    logic [BW-1:0]     beats, beat_cnt, beats_nxt;
    logic              bad;

    // Remaining length for the next burst: fresh config from IDLE, post-burst balance from RESP.
    assign rem_nxt   = (state == S_IDLE) ? cfg_len_words : rem - LEN_W'(beats);
    assign beats_nxt = (rem_nxt > LEN_W'(MAX_BURST)) ? BW'(MAX_BURST) : BW'(rem_nxt);
    assign addr_nxt  = addr + ADDR_W'(beats) * ADDR_W'(BYTES_PER_WORD);

    assign bus.m_axi_wdata   = bus.s_axis_tdata;
    assign bus.m_axi_wvalid  = (state == S_DATA) && bus.s_axis_tvalid;
    assign bus.s_axis_tready = (state == S_DATA) && bus.m_axi_wready;
    assign bus.m_axi_wlast   = (state == S_DATA) && (beat_cnt == beats - 1'b1);
    assign ap_ready          = ap_done;

`ifdef WDMA_CTRL_BRESP_CHECK_EN
    logic err_q;
    assign bad = bus.m_axi_bresp != AXI_RESP_OKAY;
    assign err = err_q;
`else
    assign bad = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state             <= S_IDLE;
            addr              <= '0;
            rem               <= '0;
            beats             <= '0;
            beat_cnt          <= '0;
            bus.m_axi_awvalid <= 1'b0;
            bus.m_axi_awaddr  <= '0;
            bus.m_axi_awlen   <= '0;
            bus.m_axi_bready  <= 1'b0;
            ap_done           <= 1'b0;
            ap_idle           <= 1'b1;
`ifdef WDMA_CTRL_BRESP_CHECK_EN
            err_q             <= 1'b0;
`endif
        end else begin
            ap_done <= 1'b0;
            case (state)
                S_IDLE: if (ap_start) begin
                    addr    <= cfg_base_addr;
                    rem     <= cfg_len_words;
                    ap_idle <= 1'b0;
`ifdef WDMA_CTRL_BRESP_CHECK_EN
                    err_q   <= 1'b0;
`endif
                    if (cfg_len_words == '0) begin
                        state   <= S_DONE;
                        ap_done <= 1'b1;
                    end else begin
                        state             <= S_ADDR;
                        beats             <= beats_nxt;
                        bus.m_axi_awvalid <= 1'b1;
                        bus.m_axi_awaddr  <= cfg_base_addr;
                        bus.m_axi_awlen   <= 8'(beats_nxt - 1'b1);
                    end
                end
                S_ADDR: if (bus.m_axi_awready) begin
                    bus.m_axi_awvalid <= 1'b0;
                    beat_cnt          <= '0;
                    state             <= S_DATA;
                end
                S_DATA: if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (bus.m_axi_wlast) begin
                        state            <= S_RESP;
                        bus.m_axi_bready <= 1'b1;
                    end
                end
                S_RESP: if (bus.m_axi_bvalid) begin
                    bus.m_axi_bready <= 1'b0;
                    addr             <= addr_nxt;
                    rem              <= rem_nxt;
`ifdef WDMA_CTRL_BRESP_CHECK_EN
                    if (bad) err_q <= 1'b1;
`endif
                    if ((rem_nxt == '0) || bad) begin
                        state   <= S_DONE;
                        ap_done <= 1'b1;
                    end else begin
                        state             <= S_ADDR;
                        beats             <= beats_nxt;
                        bus.m_axi_awvalid <= 1'b1;
                        bus.m_axi_awaddr  <= addr_nxt;
                        bus.m_axi_awlen   <= 8'(beats_nxt - 1'b1);
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    ap_idle <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wdma_ctrl.sv
// tb_wdma_ctrl: scoreboard bench for wdma_ctrl; honours WDMA_CTRL_BRESP_CHECK_EN.
module tb_wdma_ctrl;
    import wdma_pkg::*;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 24;
    localparam int MB     = 16;
`ifdef WDMA_CTRL_BRESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              ap_clk = 1'b0;
    logic              ap_rst = 1'b1;
    logic              ap_start = 1'b0;
    logic              ap_done, ap_ready, ap_idle, err;
    logic [ADDR_W-1:0] cfg_base_addr = '0;
    logic [LEN_W-1:0]  cfg_len_words = '0;

    wdma_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    wdma_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_BURST(MB)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
        .ap_ready(ap_ready), .ap_idle(ap_idle), .cfg_base_addr(cfg_base_addr),
        .cfg_len_words(cfg_len_words), .bus(bus), .err(err)
    );

    always #5 ap_clk = ~ap_clk;

    int n_tests = 0, n_fail = 0;
    logic [32:0]       exp_w[$];
    logic [ADDR_W+7:0] exp_aw[$];
    logic [ADDR_W+7:0] aw_hold;
    int   aw_cnt = 0, aw_seen = 0, b_cnt = 0, src_idx = 0, src_len = 0, lat;
    logic [7:0] src_xid = '0;
    bit   rnd = 0, inj = 0, pend_b = 0, aw_wait = 0;
    logic err_k1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rst(input string tag);
        check(tag, {ap_idle, ap_done, ap_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_wlast,
                    bus.s_axis_tready, bus.m_axi_bready, err, bus.m_axi_awaddr, bus.m_axi_awlen},
              {9'b1_0000_0000, 40'h0});
    endtask

    // Expected AW/W traffic from an independent burst model; with bresp checking an injected
    // error on the first response truncates the transfer after burst 0.
    task automatic prep(input logic [7:0] xid, input logic [31:0] base, input int len, input bit inject);
        int rem = len, w = 0, n;
        logic [31:0] a = base;
        for (int b = 0; rem > 0; b++) begin
            n = (rem < MB) ? rem : MB;
            if (!(CHK && inject && b > 0)) begin
                exp_aw.push_back({a, 8'(n - 1)});
                for (int i = 0; i < n; i++) begin
                    exp_w.push_back({(i == n - 1), xid, 24'(w)});
                    w++;
                end
            end
            rem -= n;
            a += 32'(n * 4);
        end
        src_xid = xid; src_idx = 0; src_len = len; inj = inject;
        aw_cnt = 0; aw_seen = 0; b_cnt = 0;
    endtask

    task automatic run(input logic [7:0] xid, input logic [31:0] base, input int len,
                       input bit r, input bit inject, output int l);
        prep(xid, base, len, inject);
        rnd = r;
        @(negedge ap_clk);
        check("idle_before", ap_idle, 1);
        ap_start = 1'b1; cfg_base_addr = base; cfg_len_words = LEN_W'(len);
        l = 0;
        for (int k = 1; k <= 3000 && l == 0; k++) begin
            @(negedge ap_clk);
            if (k == 1) begin
                ap_start = 1'b0; cfg_base_addr = 32'hDEAD_BEE0; cfg_len_words = 7;
                check("idle_busy", ap_idle, 0);
                err_k1 = err;
            end
            if (k == 3 && len >= 4) ap_start = 1'b1;
            if (k == 4) ap_start = 1'b0;
            if (ap_done) begin
                l = k + 1;
                check("ready_eq_done", ap_ready, 1);
            end
        end
        if (l == 0) check("done_timeout", l, 1);
        @(negedge ap_clk);
        check("done_pulse_idle", {ap_done, ap_idle}, 2'b01);
        check("w_left", exp_w.size(), 0);
        check("aw_left", exp_aw.size(), 0);
        src_len = 0;
    endtask

    // AXI slave and stream source: drive on the falling edge, sample 2 time units later.
    initial begin
        bus.s_axis_tvalid = 0; bus.s_axis_tdata = '0; bus.m_axi_awready = 0;
        bus.m_axi_wready = 0; bus.m_axi_bvalid = 0; bus.m_axi_bresp = '0;
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                bus.s_axis_tvalid = 0; bus.m_axi_awready = 0; bus.m_axi_wready = 0;
                bus.m_axi_bvalid = 0; pend_b = 0; aw_wait = 0;
            end else begin
                bus.s_axis_tvalid = (src_idx < src_len) && (!rnd || $urandom_range(0, 2) != 0);
                bus.s_axis_tdata  = {src_xid, 24'(src_idx)};
                bus.m_axi_awready = !rnd || $urandom_range(0, 2) == 0;
                bus.m_axi_wready  = !rnd || $urandom_range(0, 3) != 0;
                bus.m_axi_bvalid  = pend_b && (!rnd || $urandom_range(0, 1) == 0);
                bus.m_axi_bresp   = (inj && b_cnt == 0) ? 2'b10 : 2'b00;
                #2;
                if (aw_wait)
                    check("aw_hold", {bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awlen}, {1'b1, aw_hold});
                aw_wait = bus.m_axi_awvalid && !bus.m_axi_awready;
                aw_hold = {bus.m_axi_awaddr, bus.m_axi_awlen};
                if (bus.m_axi_awvalid) aw_seen++;
                if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                    aw_cnt++;
                    if (exp_aw.size() == 0) check("aw_extra", exp_aw.size(), 1);
                    else check("aw", {bus.m_axi_awaddr, bus.m_axi_awlen}, exp_aw.pop_front());
                end
                if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                    if (exp_w.size() == 0) check("w_extra", exp_w.size(), 1);
                    else check("w", {bus.m_axi_wlast, bus.m_axi_wdata}, exp_w.pop_front());
                    if (bus.m_axi_wlast) pend_b = 1;
                end
                if (bus.s_axis_tvalid && bus.s_axis_tready) src_idx++;
                if (bus.m_axi_bvalid && bus.m_axi_bready) begin
                    pend_b = 0;
                    b_cnt++;
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge ap_clk);
        check_rst("reset_vals");
        ap_rst = 1'b0;

        run(8'h01, 32'h1000, 16, 0, 0, lat);
        check("lat_16", lat, 20);
        check("aw_cnt_16", aw_cnt, 1);

        run(8'h02, 32'h1000, 40, 0, 0, lat);
        check("lat_40", lat, 48);
        check("aw_cnt_40", aw_cnt, 3);

        run(8'h03, 32'h1000, 0, 0, 0, lat);
        check("lat_0", lat, 2);
        check("awvalid_0", aw_seen, 0);

        run(8'h04, 32'h2000, 37, 1, 0, lat);
        check("aw_cnt_37", aw_cnt, 3);
        check("b_cnt_37", b_cnt, 3);

        run(8'h05, 32'h3000, 48, 0, 1, lat);
        check("err_slverr", err, CHK ? 1 : 0);
        check("aw_cnt_slverr", aw_cnt, CHK ? 1 : 3);

        run(8'h06, 32'h3000, 4, 0, 0, lat);
        check("err_cleared", err_k1, 0);
        check("lat_4", lat, 8);

        prep(8'h07, 32'h4000, 40, 0);
        rnd = 0;
        @(negedge ap_clk);
        ap_start = 1'b1; cfg_base_addr = 32'h4000; cfg_len_words = 40;
        @(negedge ap_clk);
        ap_start = 1'b0;
        for (int k = 0; k < 200 && aw_cnt < 2; k++) @(negedge ap_clk);
        check("second_aw", aw_cnt, 2);
        @(negedge ap_clk);
        check("in_data", bus.m_axi_wvalid, 1);
        #3 ap_rst = 1'b1;
        #1 check_rst("async_reset");
        exp_w.delete(); exp_aw.delete(); src_len = 0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        run(8'h08, 32'h5000, 4, 0, 0, lat);
        check("lat_after_rst", lat, 8);
        check("aw_cnt_after_rst", aw_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
